// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants and field packers, imported by the encoder
// and by the control unit that decodes its output.
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        OP_ADDI = 4'd0,
        OP_ORI  = 4'd1,
        OP_SLTI = 4'd2,
        OP_ANDI = 4'd3,
        OP_LW   = 4'd4,
        OP_SW   = 4'd5,
        OP_BEQ  = 4'd6,
        OP_BNE  = 4'd7,
        OP_BLT  = 4'd8,
        OP_BGE  = 4'd9,
        OP_BLTU = 4'd10,
        OP_BGEU = 4'd11,
        OP_JAL  = 4'd12
    } op_t;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_ORI  = 3'b110;
    localparam logic [2:0] F3_SLTI = 3'b010;
    localparam logic [2:0] F3_ANDI = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [6:0] opc);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    // Branch/jump offsets are passed without bit 0, which is always zero when legal.
    function automatic logic [31:0] enc_b(logic [12:1] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [6:0] opc);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:1] imm, logic [4:0] rd, logic [6:0] opc);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response handshake between an instruction producer, the encoder and
// the instruction-memory writer.
interface instr_encoder_if #(parameter int ADDR_WIDTH = 32);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_op;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [31:0]           in_imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_err;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I field packing plus immediate/opcode legality check.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        legal
);
    logic signed [31:0] simm;
    logic i_ok, b_ok, j_ok;

    assign simm = signed'(imm);
    assign i_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign b_ok = !imm[0] && (simm >= -32'sd4096) && (simm <= 32'sd4094);
    assign j_ok = !imm[0] && (simm >= -32'sd1048576) && (simm <= 32'sd1048574);

    always_comb begin
        instr = NOP;
        legal = 1'b0;
        case (op)
            OP_ADDI: begin instr = enc_i(imm[11:0], rs1, F3_ADDI, rd, OPC_OPIMM); legal = i_ok; end
            OP_ORI:  begin instr = enc_i(imm[11:0], rs1, F3_ORI,  rd, OPC_OPIMM); legal = i_ok; end
            OP_SLTI: begin instr = enc_i(imm[11:0], rs1, F3_SLTI, rd, OPC_OPIMM); legal = i_ok; end
            OP_ANDI: begin instr = enc_i(imm[11:0], rs1, F3_ANDI, rd, OPC_OPIMM); legal = i_ok; end
            OP_LW:   begin instr = enc_i(imm[11:0], rs1, F3_LW,   rd, OPC_LOAD);  legal = i_ok; end
            OP_SW:   begin instr = enc_s(imm[11:0], rs2, rs1, F3_SW, OPC_STORE);  legal = i_ok; end
            OP_BEQ:  begin instr = enc_b(imm[12:1], rs2, rs1, F3_BEQ,  OPC_BRANCH); legal = b_ok; end
            OP_BNE:  begin instr = enc_b(imm[12:1], rs2, rs1, F3_BNE,  OPC_BRANCH); legal = b_ok; end
            OP_BLT:  begin instr = enc_b(imm[12:1], rs2, rs1, F3_BLT,  OPC_BRANCH); legal = b_ok; end
            OP_BGE:  begin instr = enc_b(imm[12:1], rs2, rs1, F3_BGE,  OPC_BRANCH); legal = b_ok; end
            OP_BLTU: begin instr = enc_b(imm[12:1], rs2, rs1, F3_BLTU, OPC_BRANCH); legal = b_ok; end
            OP_BGEU: begin instr = enc_b(imm[12:1], rs2, rs1, F3_BGEU, OPC_BRANCH); legal = b_ok; end
            OP_JAL:  begin instr = enc_j(imm[20:1], rd, OPC_JAL); legal = j_ok; end
            default: begin instr = NOP; legal = 1'b0; end
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: one output register with valid/ready handshake, a
// write-address counter and a saturating illegal-request counter.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    instr_encoder_if.slave  bus,
    output logic [7:0]      err_count
);
    logic [31:0]           pack_instr;
    logic                  pack_legal;
    logic                  accept, consume;
    logic                  vld_q, err_q;
    logic [31:0]           instr_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    instr_pack u_pack (
        .op    (bus.in_op),
        .rd    (bus.in_rd),
        .rs1   (bus.in_rs1),
        .rs2   (bus.in_rs2),
        .imm   (bus.in_imm),
        .instr (pack_instr),
        .legal (pack_legal)
    );

    assign bus.in_ready  = rst_n && !flush && (!vld_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign consume       = vld_q && bus.out_ready;
    assign bus.out_valid = vld_q;
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_err   = err_q;

    // addr_q is the address of the held word, or of the next word when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
            instr_q   <= '0;
            addr_q    <= BASE_ADDR;
            err_count <= '0;
        end else if (flush) begin
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= BASE_ADDR;
        end else begin
            if (consume)
                addr_q <= addr_q + ADDR_WIDTH'(4);
            if (accept) begin
                vld_q   <= 1'b1;
                instr_q <= pack_legal ? pack_instr : NOP;
                err_q   <= !pack_legal;
                if (!pack_legal && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end else if (consume) begin
                vld_q <= 1'b0;
                err_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder: encodings, legality, stall,
// flush, error saturation, async reset and address wrap on a 4-bit instance.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic        clk, rst_n, flush_a, flush_b;
    logic [7:0]  errc_a, errc_b;
    exp_t        sb[$];
    logic [31:0] next_addr;
    int          n_vec, n_err;

    instr_encoder_if #(.ADDR_WIDTH(32)) a_if ();
    instr_encoder_if #(.ADDR_WIDTH(4))  b_if ();

    instr_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a), .bus(a_if.slave), .err_count(errc_a));
    instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(4'h0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b), .bus(b_if.slave), .err_count(errc_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Scoreboard pop: a word is checked in the cycle it is consumed.
    always @(negedge clk) begin
        if (rst_n && a_if.out_valid && a_if.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $error("FAIL unexpected_word: observed %h expected none", a_if.out_instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("instr", a_if.out_instr, e.instr);
                chk("addr", a_if.out_addr, e.addr);
                chk("err", {31'd0, a_if.out_err}, {31'd0, e.err});
            end
        end else if (rst_n && !a_if.out_valid) begin
            chk("err_idle", {31'd0, a_if.out_err}, 32'd0);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic exp_err);
        bit ok;
        ok = 0;
        a_if.in_op = op; a_if.in_rd = rd; a_if.in_rs1 = rs1; a_if.in_rs2 = rs2;
        a_if.in_imm = imm; a_if.in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (a_if.in_ready) ok = 1;
        end
        if (ok) begin
            @(posedge clk);
            sb.push_back('{instr: exp_instr, addr: next_addr, err: exp_err});
            next_addr += 32'd4;
        end else begin
            n_vec++; n_err++;
            $error("FAIL send_timeout: observed in_ready 0 expected 1");
        end
        #1 a_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $error("FAIL drain_timeout: observed %0d pending expected 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] st_addr;
        n_vec = 0; n_err = 0; next_addr = 32'h0;
        rst_n = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
        a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
        a_if.in_op = 4'd0; a_if.in_rd = 5'd0; a_if.in_rs1 = 5'd0; a_if.in_rs2 = 5'd0; a_if.in_imm = 32'd0;
        b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
        b_if.in_op = OP_ADDI; b_if.in_rd = 5'd1; b_if.in_rs1 = 5'd0; b_if.in_rs2 = 5'd0; b_if.in_imm = 32'd5;

        #3;
        chk("rst_valid", {31'd0, a_if.out_valid}, 32'd0);
        chk("rst_instr", a_if.out_instr, 32'd0);
        chk("rst_err", {31'd0, a_if.out_err}, 32'd0);
        chk("rst_addr", a_if.out_addr, 32'd0);
        chk("rst_errcnt", {24'd0, errc_a}, 32'd0);
        chk("rst_ready", {31'd0, a_if.in_ready}, 32'd0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic encodings, back-to-back with the writer always ready
        a_if.out_ready = 1'b1;
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
        @(negedge clk);
        chk("latency_valid", {31'd0, a_if.out_valid}, 32'd1);
        @(posedge clk); #1;
        send(OP_LW,  5'd2, 5'd1, 5'd0, 32'd8,  32'h0080_A103, 1'b0);
        send(OP_SW,  5'd0, 5'd1, 5'd2, 32'd4,  32'h0020_A223, 1'b0);
        send(OP_BNE, 5'd0, 5'd1, 5'd2, -32'sd4, 32'hFE20_9EE3, 1'b0);
        send(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd8,  32'h0080_00EF, 1'b0);
        send(OP_ADDI, 5'd0, 5'd0, 5'd0, -32'sd2048, 32'h8000_0013, 1'b0);
        send(OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd2047,  32'h7FF0_0013, 1'b0);
        send(OP_BEQ,  5'd0, 5'd0, 5'd0, 32'd4094,  32'h7E00_0FE3, 1'b0);
        drain();

        // Illegal requests become NOPs with the error flag
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd4096, NOP, 1'b1);
        send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd3,    NOP, 1'b1);
        drain();
        chk("errcnt_2", {24'd0, errc_a}, 32'd2);
        send(4'd13,  5'd1, 5'd0, 5'd0, 32'd0,       NOP, 1'b1);
        send(OP_BEQ, 5'd0, 5'd0, 5'd0, 32'd4096,    NOP, 1'b1);
        send(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd1048576, NOP, 1'b1);
        drain();
        chk("errcnt_5", {24'd0, errc_a}, 32'd5);

        // Stall: held word stays put, a pending request is not taken
        a_if.out_ready = 1'b0;
        st_addr = next_addr;
        send(OP_ADDI, 5'd3, 5'd0, 5'd0, 32'd1, 32'h0010_0193, 1'b0);
        a_if.in_op = OP_ADDI; a_if.in_rd = 5'd4; a_if.in_imm = 32'd2; a_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, a_if.out_valid}, 32'd1);
            chk("stall_instr", a_if.out_instr, 32'h0010_0193);
            chk("stall_addr", a_if.out_addr, st_addr);
            chk("stall_ready", {31'd0, a_if.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        a_if.out_ready = 1'b1;
        send(OP_ADDI, 5'd4, 5'd0, 5'd0, 32'd2, 32'h0020_0213, 1'b0);
        drain();

        // Flush drops the held word and refuses the concurrent request
        a_if.out_ready = 1'b0;
        send(OP_ADDI, 5'd5, 5'd0, 5'd0, 32'd3, 32'h0030_0293, 1'b0);
        void'(sb.pop_back());
        flush_a = 1'b1;
        a_if.in_op = OP_ADDI; a_if.in_rd = 5'd9; a_if.in_imm = 32'd9; a_if.in_valid = 1'b1;
        @(negedge clk);
        chk("flush_ready", {31'd0, a_if.in_ready}, 32'd0);
        @(posedge clk); #1;
        flush_a = 1'b0; a_if.in_valid = 1'b0;
        next_addr = 32'h0;
        chk("flush_valid", {31'd0, a_if.out_valid}, 32'd0);
        chk("flush_addr", a_if.out_addr, 32'd0);
        chk("flush_errcnt", {24'd0, errc_a}, 32'd5);
        a_if.out_ready = 1'b1;
        send(OP_ADDI, 5'd6, 5'd0, 5'd0, 32'd6, 32'h0060_0313, 1'b0);
        drain();

        // Error counter saturation
        for (int i = 0; i < 300; i++)
            send(4'd15, 5'd0, 5'd0, 5'd0, 32'd0, NOP, 1'b1);
        drain();
        chk("errcnt_sat", {24'd0, errc_a}, 32'd255);

        // Asynchronous reset in the middle of a stall
        a_if.out_ready = 1'b0;
        send(OP_ADDI, 5'd7, 5'd0, 5'd0, 32'd7, 32'h0070_0393, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, a_if.out_valid}, 32'd0);
        chk("arst_instr", a_if.out_instr, 32'd0);
        chk("arst_err", {31'd0, a_if.out_err}, 32'd0);
        chk("arst_addr", a_if.out_addr, 32'd0);
        chk("arst_errcnt", {24'd0, errc_a}, 32'd0);
        chk("arst_ready", {31'd0, a_if.in_ready}, 32'd0);
        sb.delete();
        next_addr = 32'h0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        a_if.out_ready = 1'b1;
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
        drain();

        // 4-bit address counter wraps after 12
        b_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] ea;
            ea = 4'(i * 4);
            @(posedge clk); #1;
            if (i == 4) b_if.in_valid = 1'b0;
            chk("wrap_valid", {31'd0, b_if.out_valid}, 32'd1);
            chk("wrap_addr", {28'd0, b_if.out_addr}, {28'd0, ea});
            chk("wrap_instr", b_if.out_instr, 32'h0050_0093);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of out_addr.
REQ-002 Parameter BASE_ADDR, default 0: first instruction-memory write address after reset or flush.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 flush  in  1  synchronous pipeline clear and address restart.
REQ-006 in_valid  in  1  request fields valid.
REQ-007 in_ready  out  1  encoder accepts request this cycle.
REQ-008 in_op  in  4  operation code, op_t: ADDI, ORI, SLTI, ANDI, LW, SW, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL.
REQ-009 in_rd, in_rs1, in_rs2  in  5 each  register indices.
REQ-010 in_imm  in  32  signed immediate or byte offset.
REQ-011 out_valid  out  1  encoded word present.
REQ-012 out_ready  in  1  instruction-memory writer consumes the word.
REQ-013 out_instr  out  32  RV32I instruction word, decodable by the team's control unit.
REQ-014 out_addr  out  ADDR_WIDTH  byte address at which out_instr is stored.
REQ-015 out_err  out  1  current word was substituted because the request was illegal.
REQ-016 err_count  out  8  saturating count of illegal requests.

Function
REQ-017 Encoding: I-type for ADDI, ORI, SLTI, ANDI (funct3 000/110/010/111, opcode 0010011) and LW (funct3 010, opcode 0000011); S-type for SW (funct3 010, opcode 0100011); B-type for BEQ/BNE/BLT/BGE/BLTU/BGEU (funct3 000/001/100/101/110/111, opcode 1100011); J-type for JAL (opcode 1101111); fields placed per RV32I bit layout.
REQ-018 Legality: I/S immediate in [-2048, 2047]; B offset even and in [-4096, 4094]; J offset even and in [-1048576, 1048574]; in_op outside op_t illegal.
REQ-019 Illegal request: out_instr = 0x00000013 (NOP), out_err = 1 for that word, err_count increments, saturating at 255.
REQ-020 Single output register; latency exactly 1 cycle from accepted request to out_valid.
REQ-021 Accept when in_valid && in_ready; in_ready = !flush && (!out_valid || out_ready).
REQ-022 While out_valid && !out_ready: out_instr, out_addr, out_err held stable.
REQ-023 Consume when out_valid && out_ready: out_addr advances by 4 for the next word; simultaneous accept and consume sustains 1 word per cycle.
REQ-024 out_addr wraps modulo 2^ADDR_WIDTH with no flag.
REQ-025 flush: out_valid to 0, out_addr to BASE_ADDR next cycle; a request presented in the flush cycle is not accepted; err_count unaffected.
REQ-026 out_err is 0 whenever out_valid is 0.

Reset
REQ-027 rst_n low: immediately out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_count=0; in_ready is 0 while reset is asserted.
REQ-028 Reset mid-transfer discards the held word; first accepted request after release is written at BASE_ADDR.

Structure
REQ-029 op_t, opcode and funct3 constants, and the NOP constant reside in a shared package also imported by the control unit.
REQ-030 Combinational field packing and legality check reside in one sub-module, instr_pack; instr_encoder holds the register, handshake, address counter and error counter.

Verification
REQ-031 ADDI rd=1 rs1=0 imm=5 -> next cycle out_instr=0x00500093, out_addr=BASE_ADDR, out_err=0.
REQ-032 LW rd=2 rs1=1 imm=8 then SW rs1=1 rs2=2 imm=4, out_ready=1 -> 0x0080A103 at addr 0, 0x0020A223 at addr 4, back-to-back.
REQ-033 BNE rs1=1 rs2=2 imm=-4 -> 0xFE209EE3; JAL rd=1 imm=8 -> 0x008000EF.
REQ-034 ADDI imm=4096 and BEQ imm=3 -> NOP 0x00000013 with out_err=1 each, err_count=2; 300 illegal requests -> err_count=255.
REQ-035 out_ready=0 for 5 cycles with word held -> out_instr/out_addr stable, in_ready=0, no request lost; flush asserted with in_valid=1 -> out_valid=0, next accepted word at BASE_ADDR.
REQ-036 ADDR_WIDTH=4, 5 consumed words -> addresses 0,4,8,12,0; rst_n pulsed low mid-stall -> outputs at reset values asynchronously.
